// File: rtl/spi_slave_sync.sv
// SPI slave (mode 0, LSB first) oversampled in the clk domain through input synchronizers.
// All outputs are registered; one FSM tracks the frame and shifts bytes in/out.
module spi_slave_sync #(
  parameter int unsigned BYTE_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  spi_nss,
  input  logic                  spi_sck,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [BYTE_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_first,
  input  logic [BYTE_WIDTH-1:0] tx_data,
  output logic                  tx_load,
  output logic                  frame_active,
  output logic                  frame_end
);

  localparam int unsigned CntW = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                  state_q;
  logic [SYNC_STAGES-1:0]  nss_sync_q, sck_sync_q, mosi_sync_q, flush_q;
  logic                    sck_prev_q, nss_high_q, first_q;
  logic [CntW-1:0]         bit_cnt_q;
  logic [BYTE_WIDTH-1:0]   rx_sr_q, tx_sr_q, rx_assembled;
  logic                    nss_s, sck_s, mosi_s;
  logic                    sck_rise, sck_fall, nss_fall, last_bit;

  assign nss_s  = nss_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  // nss_high_q only becomes set once the synchronizer holds real pin samples, so a
  // slave select that is already low when reset releases never looks like a falling edge.
  assign nss_fall = ~nss_s & nss_high_q;
  assign last_bit = (bit_cnt_q == CntW'(BYTE_WIDTH - 1));

  always_comb begin
    rx_assembled            = rx_sr_q;
    rx_assembled[bit_cnt_q] = mosi_s;
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      nss_sync_q  <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      flush_q     <= '0;
      sck_prev_q  <= 1'b0;
      nss_high_q  <= 1'b0;
    end else begin
      nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], spi_nss};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      flush_q     <= {flush_q[SYNC_STAGES-2:0], 1'b1};
      sck_prev_q  <= sck_s;
      nss_high_q  <= flush_q[SYNC_STAGES-1] & nss_s;
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      rx_sr_q      <= '0;
      tx_sr_q      <= '0;
      first_q      <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_first     <= 1'b0;
      tx_load      <= 1'b0;
      frame_active <= 1'b0;
      frame_end    <= 1'b0;
      spi_miso     <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      rx_first  <= 1'b0;
      tx_load   <= 1'b0;
      frame_end <= 1'b0;
      unique case (state_q)
        StIdle: begin
          spi_miso     <= 1'b0;
          frame_active <= 1'b0;
          if (nss_fall) begin
            state_q      <= StShift;
            bit_cnt_q    <= '0;
            rx_sr_q      <= '0;
            tx_sr_q      <= tx_data;
            tx_load      <= 1'b1;
            spi_miso     <= tx_data[0];
            first_q      <= 1'b1;
            frame_active <= 1'b1;
          end
        end
        StShift: begin
          // Slave select release has priority over a coincident sck edge.
          if (nss_s) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            frame_end    <= 1'b1;
            frame_active <= 1'b0;
            spi_miso     <= 1'b0;
          end else if (sck_rise) begin
            rx_sr_q <= rx_assembled;
            if (last_bit) begin
              rx_data   <= rx_assembled;
              rx_valid  <= 1'b1;
              rx_first  <= first_q;
              first_q   <= 1'b0;
              bit_cnt_q <= '0;
              tx_sr_q   <= tx_data;
              tx_load   <= 1'b1;
              spi_miso  <= tx_data[0];
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (sck_fall) begin
            spi_miso <= tx_sr_q[bit_cnt_q];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: a bit-banged SPI master plus a receive scoreboard.
module tb_spi_slave_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_nss, spi_sck, spi_mosi, spi_miso;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_first, tx_load, frame_active, frame_end;

  int n_checks = 0;
  int n_fail   = 0;
  int rx_cnt   = 0;
  int tl_cnt   = 0;
  int fe_cnt   = 0;
  logic [8:0] exp_q[$];
  logic [7:0] prev_rx = 8'h00;

  spi_slave_sync dut (
    .clk          (clk),
    ._reset       (rst_n),
    .spi_nss      (spi_nss),
    .spi_sck      (spi_sck),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_first     (rx_first),
    .tx_data      (tx_data),
    .tx_load      (tx_load),
    .frame_active (frame_active),
    .frame_end    (frame_end)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every rx_valid must match the oldest byte the master sent.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_load) tl_cnt++;
      if (frame_end) fe_cnt++;
      if (rx_valid) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          check("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e[7:0]));
          check("rx_first", 32'(rx_first), 32'(e[8]));
        end
      end else if (rx_data !== prev_rx) begin
        check("rx_hold", 32'(rx_data), 32'(prev_rx));
      end
    end
    prev_rx = rx_data;
  end

  task automatic send_bits(input logic [7:0] mosi_b, input logic [7:0] next_tx, input int half,
                           input int nbits, output logic [7:0] miso_b);
    tx_data = next_tx;
    miso_b  = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi_b[i];
      repeat (half) @(negedge clk);
      miso_b[i] = spi_miso;
      spi_sck = 1'b1;
      repeat (half) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] mosi_b, input logic [7:0] next_tx, input int half,
                      input logic first, output logic [7:0] miso_b);
    exp_q.push_back({first, mosi_b});
    send_bits(mosi_b, next_tx, half, 8, miso_b);
  endtask

  task automatic start_frame();
    spi_nss = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic stop_frame();
    repeat (4) @(negedge clk);
    spi_nss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  function automatic logic [31:0] outs();
    return 32'({rx_data, rx_valid, rx_first, tx_load, frame_active, frame_end, spi_miso});
  endfunction

  initial begin
    logic [7:0] mb;
    logic [7:0] bytes3[3];
    logic [7:0] miso3[3];
    logic [7:0] bytes4[4];
    logic [7:0] tx4[5];
    int rx0, fe0, tl0;
    logic miso_seen;

    rst_n = 1'b0; spi_nss = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0; tx_data = 8'h3C;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 32'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_outputs", outs(), 32'h0);

    // Single byte frame
    rx0 = rx_cnt; fe0 = fe_cnt;
    start_frame();
    check("frame_active", 32'(frame_active), 32'h1);
    xfer(8'h41, 8'h00, 4, 1'b1, mb);
    check("miso_single", 32'(mb), 32'h3C);
    stop_frame();
    check("single_rx_count", 32'(rx_cnt - rx0), 32'd1);
    check("single_frame_end", 32'(fe_cnt - fe0), 32'd1);
    check("single_inactive", 32'({frame_active, spi_miso}), 32'h0);

    // Three bytes, reply with the complement of each received byte
    bytes3 = '{8'h29, 8'h2A, 8'h32};
    miso3  = '{8'h3C, 8'hD6, 8'hD5};
    rx0 = rx_cnt;
    tx_data = 8'h3C;
    start_frame();
    for (int i = 0; i < 3; i++) begin
      xfer(bytes3[i], ~bytes3[i], 4, (i == 0), mb);
      check("miso_multi", 32'(mb), 32'(miso3[i]));
    end
    stop_frame();
    check("multi_rx_count", 32'(rx_cnt - rx0), 32'd3);

    // Truncated frame, then a clean restart
    rx0 = rx_cnt; fe0 = fe_cnt;
    start_frame();
    send_bits(8'h1F, 8'h00, 4, 5, mb);
    stop_frame();
    check("trunc_rx_count", 32'(rx_cnt - rx0), 32'd0);
    check("trunc_frame_end", 32'(fe_cnt - fe0), 32'd1);
    start_frame();
    xfer(8'h91, 8'h00, 4, 1'b1, mb);
    stop_frame();
    check("restart_rx_count", 32'(rx_cnt - rx0), 32'd1);

    // Reset mid-frame with nss held low
    rx0 = rx_cnt; fe0 = fe_cnt; tl0 = tl_cnt;
    start_frame();
    send_bits(8'h0F, 8'h00, 4, 4, mb);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_outputs", outs(), 32'h0);
    tl0 = tl_cnt;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_bits(8'hFF, 8'h00, 4, 8, mb);
    repeat (6) @(negedge clk);
    check("postreset_rx_count", 32'(rx_cnt - rx0), 32'd0);
    check("postreset_tx_load", 32'(tl_cnt - tl0), 32'd0);
    check("postreset_outputs", outs(), 32'h0);
    spi_nss = 1'b1;
    repeat (6) @(negedge clk);
    check("postreset_no_frame_end", 32'(fe_cnt - fe0), 32'd0);
    start_frame();
    xfer(8'h5A, 8'h00, 4, 1'b1, mb);
    stop_frame();
    check("postreset_recover", 32'(rx_cnt - rx0), 32'd1);

    // sck activity while deselected
    rx0 = rx_cnt; tl0 = tl_cnt;
    miso_seen = 1'b0;
    spi_mosi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      repeat (3) @(negedge clk);
      miso_seen |= spi_miso;
      spi_sck = 1'b1;
      repeat (3) @(negedge clk);
      miso_seen |= spi_miso;
      spi_sck = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("idle_sck_rx", 32'(rx_cnt - rx0), 32'd0);
    check("idle_sck_tx_load", 32'(tl_cnt - tl0), 32'd0);
    check("idle_sck_miso", 32'(miso_seen), 32'd0);

    // Minimum sck high/low time, back-to-back bytes
    bytes4 = '{8'h01, 8'h02, 8'h04, 8'h08};
    tx4    = '{8'h10, 8'h20, 8'h40, 8'h80, 8'hFF};
    rx0 = rx_cnt;
    tx_data = tx4[0];
    start_frame();
    for (int i = 0; i < 4; i++) begin
      xfer(bytes4[i], tx4[i+1], 3, (i == 0), mb);
      check("miso_fast", 32'(mb), 32'(tx4[i]));
    end
    stop_frame();
    check("fast_rx_count", 32'(rx_cnt - rx0), 32'd4);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_sync.md
SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 Parameter: BYTE_WIDTH, default 8, bits per SPI transfer.
REQ-002 Parameter: SYNC_STAGES, default 2, flip-flop depth of each input synchronizer (minimum 2).
REQ-003 Port: clk  in  1  system clock; single clock domain; all outputs registered on its rising edge.
REQ-004 Port: _reset  in  1  asynchronous, active-low reset.
REQ-005 Port: spi_nss  in  1  SPI slave select, active-low, asynchronous to clk.
REQ-006 Port: spi_sck  in  1  SPI clock, idle low, asynchronous to clk.
REQ-007 Port: spi_mosi  in  1  SPI data in, LSB first, sampled on sck rising edge.
REQ-008 Port: spi_miso  out  1  SPI data out, LSB first, changes only after sck falling edges or at byte start.
REQ-009 Port: rx_data  out  BYTE_WIDTH  last complete byte received; held until the next complete byte.
REQ-010 Port: rx_valid  out  1  one-clk pulse; rx_data is new this cycle.
REQ-011 Port: rx_first  out  1  high with rx_valid when the byte is the first of the current frame.
REQ-012 Port: tx_data  in  BYTE_WIDTH  byte to be shifted out in the next transfer.
REQ-013 Port: tx_load  out  1  one-clk pulse; tx_data was captured this cycle and may change from the next cycle.
REQ-014 Port: frame_active  out  1  high while the synchronized nss is low.
REQ-015 Port: frame_end  out  1  one-clk pulse on the synchronized nss rising edge.

Function
REQ-016 nss, sck and mosi each SHALL pass through a SYNC_STAGES flip-flop synchronizer; all logic SHALL use the synchronized copies only.
REQ-017 sck edges SHALL be detected by comparing the synchronized sck with a one-cycle-delayed copy.
REQ-018 Correct operation SHALL be guaranteed for an sck high time and low time each of at least 3 clk periods.
REQ-019 FSM states: IDLE (nss high) and SHIFT (nss low); IDLE->SHIFT on the synchronized nss falling edge; SHIFT->IDLE on the synchronized nss rising edge.
REQ-020 On IDLE->SHIFT: clear the bit counter, capture tx_data into the tx shift register, pulse tx_load, drive spi_miso with tx_data[0], and set the first-byte flag.
REQ-021 In SHIFT, on each sck rising edge: shift the synchronized mosi into rx shift register bit position [bit counter]; increment the bit counter.
REQ-022 On the rising edge that completes bit BYTE_WIDTH-1: on the next clk, rx_data = assembled byte, rx_valid = 1, rx_first = first-byte flag; then clear the first-byte flag, reset the bit counter to 0, capture tx_data, and pulse tx_load.
REQ-023 In SHIFT, on each sck falling edge: spi_miso = next tx shift bit; after a byte completes, the captured bit 0 of the new byte SHALL already be on spi_miso.
REQ-024 In IDLE: spi_miso = 0; sck edges are ignored; rx_valid and tx_load stay 0.
REQ-025 nss rising mid-byte: discard the partial byte with no rx_valid; pulse frame_end; clear the bit counter.
REQ-026 A synchronized nss rise and sck rise detected in the same clk: nss wins; the edge is ignored and the byte is not completed.
REQ-027 A new frame SHALL restart cleanly after any prior frame, including a truncated one.
REQ-028 Back-to-back bytes within one frame SHALL be received without gaps; rx_data changes only on rx_valid.

Reset
REQ-029 While _reset is low: FSM = IDLE; synchronizers = nss 1, sck 0, mosi 0; counters and shift registers 0; rx_data = 0; rx_valid = rx_first = tx_load = frame_end = frame_active = spi_miso = 0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; after release, the block waits in IDLE for a fresh nss falling edge, even if nss is already low.

Verification
REQ-031 Frame of one byte 0x41 (sck 8 clk/period) -> exactly one rx_valid, rx_data = 0x41, rx_first = 1, frame_end once after nss rises.
REQ-032 Frame of bytes 0x29, 0x2A, 0x32 with tx_data returned as ~rx -> rx_valid x3, rx_first only on 0x29; bench-captured miso = tx_data captured at frame start, then 0xD6, 0xD5.
REQ-033 nss raised after 5 bits -> no rx_valid, frame_end = 1; next frame byte 0x91 -> rx_data = 0x91, rx_first = 1.
REQ-034 Reset pulsed low after bit 3 with nss held low -> all outputs 0; no rx_valid until nss toggles high then low.
REQ-035 sck edges while nss is high -> no rx_valid, no tx_load, spi_miso = 0.
REQ-036 Minimum timing, sck high = low = 3 clk, 4 bytes 0x01, 0x02, 0x04, 0x08 -> all received correctly with matching miso bits.
